// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared constants, glyph codes and leading-zero helper for the scan controller
package seg7_pkg;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] AN_OFF    = 8'hFF;

  // Active-low {DP,g,f,e,d,c,b,a} with the decimal point off
  localparam logic [7:0] GLYPH_0 = 8'hC0;
  localparam logic [7:0] GLYPH_1 = 8'hF9;
  localparam logic [7:0] GLYPH_2 = 8'hA4;
  localparam logic [7:0] GLYPH_3 = 8'hB0;
  localparam logic [7:0] GLYPH_4 = 8'h99;
  localparam logic [7:0] GLYPH_5 = 8'h92;
  localparam logic [7:0] GLYPH_6 = 8'h82;
  localparam logic [7:0] GLYPH_7 = 8'hF8;
  localparam logic [7:0] GLYPH_8 = 8'h80;
  localparam logic [7:0] GLYPH_9 = 8'h90;
  localparam logic [7:0] GLYPH_A = 8'h88;
  localparam logic [7:0] GLYPH_B = 8'h83;
  localparam logic [7:0] GLYPH_C = 8'hC6;
  localparam logic [7:0] GLYPH_D = 8'hA1;
  localparam logic [7:0] GLYPH_E = 8'h86;
  localparam logic [7:0] GLYPH_F = 8'h8E;

  // Bit i set when nibbles i..7 are all zero; bit 0 is never set so the
  // least significant digit always shows.
  function automatic logic [7:0] lz_mask(input logic [31:0] value);
    logic       all_zero;
    logic [7:0] mask;
    all_zero = 1'b1;
    mask     = '0;
    for (int i = 7; i >= 1; i--) begin
      all_zero = all_zero & (value[4*i +: 4] == 4'h0);
      mask[i]  = all_zero;
    end
    return mask;
  endfunction

endpackage

// File: rtl/seg7_glyph_rom.sv
// rtl/seg7_glyph_rom.sv - hex nibble to active-low 7-segment glyph
module seg7_glyph_rom
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] glyph
);

  always_comb begin
    glyph = GLYPH_0[6:0];
    case (nibble)
      4'h0: glyph = GLYPH_0[6:0];
      4'h1: glyph = GLYPH_1[6:0];
      4'h2: glyph = GLYPH_2[6:0];
      4'h3: glyph = GLYPH_3[6:0];
      4'h4: glyph = GLYPH_4[6:0];
      4'h5: glyph = GLYPH_5[6:0];
      4'h6: glyph = GLYPH_6[6:0];
      4'h7: glyph = GLYPH_7[6:0];
      4'h8: glyph = GLYPH_8[6:0];
      4'h9: glyph = GLYPH_9[6:0];
      4'hA: glyph = GLYPH_A[6:0];
      4'hB: glyph = GLYPH_B[6:0];
      4'hC: glyph = GLYPH_C[6:0];
      4'hD: glyph = GLYPH_D[6:0];
      4'hE: glyph = GLYPH_E[6:0];
      4'hF: glyph = GLYPH_F[6:0];
      default: glyph = GLYPH_0[6:0];
    endcase
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// rtl/seg7_scan_ctrl.sv - 8-digit multiplexed 7-segment scanner with frame-synchronous value commit
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int SCAN_DIV   = 100000,
  parameter int NUM_DIGITS = 8,
  parameter int LZ_BLANK   = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_valid,
  input  logic [31:0] wr_data,
  input  logic [7:0]  wr_dp,
  output logic        wr_ready,
  input  logic [7:0]  digit_en,
  output logic [7:0]  an,
  output logic [7:0]  seg,
  output logic        frame_tick
);

  localparam int             PW        = $clog2(SCAN_DIV);
  localparam logic [PW-1:0]  PRESC_MAX = PW'(SCAN_DIV - 1);
  localparam logic [2:0]     IDX_MAX   = 3'(NUM_DIGITS - 1);

  logic [PW-1:0] presc;
  logic [2:0]    idx;
  logic          tc;
  logic          boundary;

  logic [31:0]   pend_data;
  logic [7:0]    pend_dp;
  logic          pend_flag;
  logic [31:0]   shadow_data;
  logic [7:0]    shadow_dp;
  logic          xfer;
  logic          commit;

  logic [3:0]    nibble;
  logic [6:0]    glyph;
  logic [7:0]    lz;
  logic          suppressed;

  assign tc       = (presc == PRESC_MAX);
  assign boundary = tc && (idx == IDX_MAX);
  assign xfer     = wr_valid && wr_ready;
  assign commit   = boundary && pend_flag;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc      <= '0;
      idx        <= '0;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= boundary;
      if (tc) begin
        presc <= '0;
        idx   <= (idx == IDX_MAX) ? 3'd0 : idx + 3'd1;
      end else begin
        presc <= presc + 1'b1;
      end
    end
  end

  // Pending and shadow are mutually exclusive owners: wr_ready is low exactly
  // while a value waits, so a commit and a new transfer never share a cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_data   <= '0;
      pend_dp     <= '0;
      pend_flag   <= 1'b0;
      shadow_data <= '0;
      shadow_dp   <= '0;
      wr_ready    <= 1'b1;
    end else if (commit) begin
      shadow_data <= pend_data;
      shadow_dp   <= pend_dp;
      pend_flag   <= 1'b0;
      wr_ready    <= 1'b1;
    end else if (xfer) begin
      pend_data   <= wr_data;
      pend_dp     <= wr_dp;
      pend_flag   <= 1'b1;
      wr_ready    <= 1'b0;
    end
  end

  assign nibble = shadow_data[{idx, 2'b00} +: 4];

  seg7_glyph_rom u_glyph_rom (
    .nibble (nibble),
    .glyph  (glyph)
  );

  always_comb begin
    lz         = lz_mask(shadow_data);
    suppressed = !digit_en[idx] || ((LZ_BLANK != 0) && lz[idx]);
  end

  // Blanking on tc lands in the slot's first cycle, hiding the anode switch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an  <= AN_OFF;
      seg <= SEG_BLANK;
    end else if (tc || suppressed) begin
      an  <= AN_OFF;
      seg <= SEG_BLANK;
    end else begin
      an  <= ~(8'h01 << idx);
      seg <= {~shadow_dp[idx], glyph};
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb/tb_seg7_scan_ctrl.sv - directed table-driven bench for seg7_scan_ctrl with SCAN_DIV=4
module tb_seg7_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_valid;
  logic [31:0] wr_data;
  logic [7:0]  wr_dp;
  logic        wr_ready;
  logic [7:0]  digit_en;
  logic [7:0]  an;
  logic [7:0]  seg;
  logic        frame_tick;

  int n_checks = 0;
  int n_errors = 0;

  seg7_scan_ctrl #(.SCAN_DIV(4), .NUM_DIGITS(8), .LZ_BLANK(1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_valid   (wr_valid),
    .wr_data    (wr_data),
    .wr_dp      (wr_dp),
    .wr_ready   (wr_ready),
    .digit_en   (digit_en),
    .an         (an),
    .seg        (seg),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [7:0]  dp;
    logic [7:0]  en;
    logic [7:0]  lit;
    logic [63:0] segs;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  task automatic do_write(input logic [31:0] data, input logic [7:0] dp);
    int cnt;
    cnt = 0;
    while (!wr_ready && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    wr_valid = 1'b1;
    wr_data  = data;
    wr_dp    = dp;
    @(negedge clk);
    wr_valid = 1'b0;
    check("ready_low_after_xfer", 8'(wr_ready), 8'h00);
  endtask

  task automatic wait_commit();
    int cnt;
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!wr_ready && cnt < 100);
    check("commit_ready", 8'(wr_ready), 8'h01);
    check("commit_tick", 8'(frame_tick), 8'h01);
  endtask

  task automatic check_frame(input int v);
    logic [7:0] one;
    logic [7:0] exp_an;
    logic [7:0] exp_seg;
    one = 8'h01;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("v%0d_gap_an_d%0d", v, i), an, 8'hFF);
      check($sformatf("v%0d_gap_seg_d%0d", v, i), seg, 8'hFF);
      @(negedge clk);
      exp_an  = vecs[v].lit[i] ? ~(one << i) : 8'hFF;
      exp_seg = vecs[v].lit[i] ? vecs[v].segs[8*i +: 8] : 8'hFF;
      check($sformatf("v%0d_an_d%0d", v, i), an, exp_an);
      check($sformatf("v%0d_seg_d%0d", v, i), seg, exp_seg);
      repeat (3) @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int cnt;
    vecs[0] = '{32'h0000_00A5, 8'h00, 8'hFF, 8'h03, 64'hFFFF_FFFF_FFFF_8892};
    vecs[1] = '{32'h1234_5678, 8'h01, 8'hFF, 8'hFF, 64'hF9A4_B099_9282_F800};
    vecs[2] = '{32'h0000_0003, 8'h00, 8'hFE, 8'h00, 64'hFFFF_FFFF_FFFF_FFFF};
    vecs[3] = '{32'h0050_00C0, 8'h84, 8'hFF, 8'h3F, 64'hFFFF_92C0_C040_C6C0};
    vecs[4] = '{32'hFEDC_BA90, 8'h00, 8'h5A, 8'h5A, 64'hFF86_FFC6_83FF_90FF};

    rst_n    = 1'b0;
    wr_valid = 1'b0;
    wr_data  = '0;
    wr_dp    = '0;
    digit_en = 8'hFF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_an", an, 8'hFF);
    check("rst_seg", seg, 8'hFF);
    check("rst_ready", 8'(wr_ready), 8'h01);
    check("rst_tick", 8'(frame_tick), 8'h00);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_an_d0", an, 8'hFE);
    check("post_rst_seg_d0", seg, 8'hC0);
    repeat (4) @(negedge clk);
    check("post_rst_an_d1", an, 8'hFF);
    check("post_rst_seg_d1", seg, 8'hFF);

    for (int v = 0; v < 5; v++) begin
      digit_en = vecs[v].en;
      do_write(vecs[v].data, vecs[v].dp);
      wait_commit();
      check_frame(v);
    end

    // Transfer landing exactly on a frame boundary, plus writes while busy
    digit_en = 8'hFF;
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!frame_tick && cnt < 100);
    check("align_tick", 8'(frame_tick), 8'h01);
    repeat (31) @(negedge clk);
    wr_valid = 1'b1;
    wr_data  = 32'h0000_0001;
    wr_dp    = 8'h00;
    @(negedge clk);
    check("bnd_tick", 8'(frame_tick), 8'h01);
    check("bnd_ready", 8'(wr_ready), 8'h00);
    wr_data = 32'h0000_0002;
    @(negedge clk);
    check("bnd_old_an", an, 8'hFE);
    check("bnd_old_seg", seg, 8'hC0);
    check("bnd_busy_ready", 8'(wr_ready), 8'h00);
    @(negedge clk);
    wr_valid = 1'b0;
    cnt = 2;
    do begin
      @(negedge clk);
      cnt++;
    end while (!wr_ready && cnt < 100);
    check("bnd_commit_delay", 8'(cnt), 8'd32);
    check("bnd_commit_tick", 8'(frame_tick), 8'h01);
    @(negedge clk);
    check("bnd_new_an", an, 8'hFE);
    check("bnd_new_seg", seg, 8'hF9);

    cnt = 1;
    do begin
      @(negedge clk);
      cnt++;
    end while (!frame_tick && cnt < 100);
    check("tick_period", 8'(cnt), 8'd32);
    @(negedge clk);
    check("tick_one_cycle", 8'(frame_tick), 8'h00);
    check("pre_areset_an", an, 8'hFE);
    check("pre_areset_seg", seg, 8'hF9);

    // Asynchronous reset pulse between clock edges
    #1;
    rst_n = 1'b0;
    #1;
    check("areset_an", an, 8'hFF);
    check("areset_seg", seg, 8'hFF);
    check("areset_ready", 8'(wr_ready), 8'h01);
    check("areset_tick", 8'(frame_tick), 8'h00);
    rst_n = 1'b1;
    @(negedge clk);
    check("after_areset_an", an, 8'hFE);
    check("after_areset_seg", seg, 8'hC0);
    check("after_areset_ready", 8'(wr_ready), 8'h01);
    repeat (4) @(negedge clk);
    check("after_areset_an_d1", an, 8'hFF);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/seg7_scan_ctrl.md
Name: seg7_scan_ctrl

Overview:
- Time-multiplexed scan controller for the board's 8-digit common-anode 7-segment display.
- Accepts a 32-bit value (8 hex nibbles) plus per-digit decimal points through a valid/ready write port, e.g. from the CPU's debug/IO register.
- Commits new values only at frame boundaries, so the display never tears.
- Cycles the digit anodes and drives active-low segment codes, with optional leading-zero blanking and anti-ghost blanking.

Parameters:
- SCAN_DIV, 100000, clk cycles per digit slot; legal range 2..2^20.
- NUM_DIGITS, 8, digits scanned; fixed at 8 in this revision.
- LZ_BLANK, 1, 1 = blank leading zero digits (digit 0 is never blanked).

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous assert, active-low
- wr_valid  in  1  write request
- wr_data  in  32  hex value; nibble i (bits 4i+3..4i) drives digit i
- wr_dp  in  8  decimal point per digit; 1 = lit
- wr_ready  out  1  write port can accept
- digit_en  in  8  static per-digit enable; 0 forces the digit off
- an  out  8  anode enables, active-low; bit i = digit i
- seg  out  8  {DP,g,f,e,d,c,b,a}, active-low
- frame_tick  out  1  one-cycle pulse at each frame boundary

Behaviour:
- Reset (rst_n=0, async) drives: an=8'hFF, seg=8'hFF, wr_ready=1, frame_tick=0, prescaler=0, digit index=0, shadow data/dp=0, pending flag=0.
- Prescaler:
  - Counts 0..SCAN_DIV-1 and wraps.
  - Terminal count (TC) occurs when prescaler==SCAN_DIV-1.
  - At TC the digit index increments; after NUM_DIGITS-1 it wraps to 0.
- Frame boundary: TC with index==NUM_DIGITS-1. frame_tick=1 in the cycle after the boundary, i.e. the same cycle the index becomes 0.
- Write handshake:
  - A transfer occurs on wr_valid && wr_ready. It captures wr_data and wr_dp into the pending register and sets the pending flag.
  - wr_ready is registered: it goes 0 the cycle after a transfer.
- Commit:
  - At a frame boundary with the pending flag set (registered value): shadow <= pending, flag cleared, wr_ready=1 next cycle.
  - If a transfer and a boundary coincide while the flag is clear, the new data waits for the next boundary.
  - A second write while pending is impossible, because wr_ready=0.
  - wr_valid while wr_ready=0 is ignored; data is not latched.
- Digit decode:
  - Uses the shadow nibble of the current index: hex 0-F maps to standard glyphs (A, b, C, d, E, F shapes).
  - seg[7] = ~shadow_dp[index].
- Anode:
  - an[index]=0 and all other bits 1, unless the digit is suppressed.
  - Suppressed when: digit_en[index]=0, OR (LZ_BLANK=1 AND index!=0 AND every shadow nibble from index up to 7 is zero). A lit DP does not cancel blanking.
  - A suppressed digit gives an=8'hFF and seg=8'hFF.
- Anti-ghost: during the cycle where prescaler==0, an=8'hFF and seg=8'hFF.
- Latency:
  - an and seg are registered, so they reflect the new index 1 cycle after TC.
  - Write to display: at most 1 frame + 2 cycles after the first boundary following the transfer.
- digit_en is sampled every cycle; no synchronizer is required (static config).
- Reset mid-frame: immediate blank, then restart from digit 0 with shadow=0. With LZ_BLANK=1 the display reads "0" on digit 0.

Decomposition:
- Package seg7_pkg holds:
  - SEG_BLANK=8'hFF, AN_OFF=8'hFF
  - glyph constants for 0-F (8-bit active-low)
  - function for the leading-zero mask
- Sub-module seg7_glyph_rom: combinational 4-bit nibble to 7-bit active-low glyph, instantiated once on the muxed nibble.
- Prescaler, index, handshake and output registers stay in the top module.

Test Plan:
- Reset with SCAN_DIV=4 → an=FF, seg=FF, wr_ready=1. After release: digit 0 shows C0 (glyph "0"), digits 1-7 stay blank.
- Write 32'h0000_00A5, dp=0, digit_en=FF → after the next frame boundary, digit0 seg=92, digit1 seg=88, digits 2-7 an=FF. wr_ready low from transfer until 1 cycle after commit.
- Write 32'h1234_5678, dp=8'h01 → digit0 seg=0x00 (8 with DP lit); digit7 seg=F9. Every slot starts with a 1-cycle an=FF gap.
- Transfer in the exact cycle of a frame boundary → old shadow is held for one more frame; commit occurs at the following boundary. Also check wr_valid asserted while wr_ready=0 is not latched.
- digit_en=8'hFE with data 32'h0000_0003 → digit 0 never driven (an stays FF in its slot); frame_tick pulses every 8×SCAN_DIV cycles.
- Assert rst_n low mid-slot for 1 ns (no clock edge) → an and seg go FF immediately. After release: shadow=0, wr_ready=1, index restarts at 0.
